// File: rtl/mic4_pulse_sequencer.sv
// Purpose: sequences pulse_grst / pulse_a / pulse_d triggers for the Mic4 pulse stretchers (optional GRST, then N shots).
// Latency: outputs registered; first visible effect is the cycle after start is sampled in IDLE.
// Backpressure: none; start is ignored while busy and abort returns to IDLE at the next edge. Macro MIC4_SEQ_EXT_TRIG_EN adds ext_trig shot pacing.
module mic4_pulse_sequencer #(
  parameter int DELAY_WIDTH = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int GRST_GUARD  = 8   // must be >= 1: guard cycles counted from the grst trigger
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
`ifdef MIC4_SEQ_EXT_TRIG_EN
  input  logic                   ext_trig,
`endif
  input  logic                   cfg_grst_en,
  input  logic [DELAY_WIDTH-1:0] cfg_a_delay,
  input  logic [DELAY_WIDTH-1:0] cfg_d_delay,
  input  logic [DELAY_WIDTH-1:0] cfg_period,
  input  logic [COUNT_WIDTH-1:0] cfg_repeat,
  output logic                   pulse_grst,
  output logic                   pulse_a,
  output logic                   pulse_d,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] shot_count
);

  // Wait counter is wide enough to hold GRST_GUARD + a_delay and period + 1 without overflow.
  localparam int CNT_W = DELAY_WIDTH + 2;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
  localparam logic [CNT_W-1:0] G_CNT  = CNT_W'(GRST_GUARD);
  localparam logic [COUNT_WIDTH-1:0] SHOT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRST, S_WAIT_A, S_FIRE_A, S_WAIT_D, S_FIRE_D, S_WAIT_P, S_DONE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_grst_en;
  logic [DELAY_WIDTH-1:0] r_a_delay, r_d_delay, r_period;
  logic [COUNT_WIDTH-1:0] r_repeat, r_shot_count;
  logic                   r_pulse_grst, r_pulse_a, r_pulse_d, r_busy, r_done;

  logic                   w_start_acc;
  logic [CNT_W-1:0]       w_a_in, w_a_sh, w_d_eff, w_p_raw, w_p_eff, w_gap;
  logic                   w_last_shot;
  logic                   w_trig_edge;

  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_a_in      = CNT_W'(cfg_a_delay);
  assign w_a_sh      = CNT_W'(r_a_delay);
  assign w_d_eff     = (r_d_delay == '0) ? ONE : CNT_W'(r_d_delay);
  assign w_p_raw     = CNT_W'(r_period);
  assign w_p_eff     = (w_p_raw > w_d_eff) ? w_p_raw : (w_d_eff + ONE);
  // Idle cycles between a pulse_d and the next pulse_a.
  assign w_gap       = w_p_eff - w_d_eff - ONE;
  // shot_count already includes the pulse_d currently on the output.
  assign w_last_shot = (r_repeat != '0) && (r_shot_count == r_repeat);

`ifdef MIC4_SEQ_EXT_TRIG_EN
  logic [1:0] r_trig_sync;
  logic       r_trig_prev;

  // Two-flop synchronizer plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_trig_sync <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_sync <= {r_trig_sync[0], ext_trig};
      r_trig_prev <= r_trig_sync[1];
    end
  end

  assign w_trig_edge = r_trig_sync[1] && !r_trig_prev;
`else
  assign w_trig_edge = 1'b0;
`endif

  // Next-state and wait-counter reload; a wait state entered with count n lasts n+1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          if (cfg_grst_en) begin
            w_state_nxt = S_GRST;
          end else begin
`ifdef MIC4_SEQ_EXT_TRIG_EN
            w_state_nxt = S_WAIT_P;
            w_cnt_nxt   = '0;
`else
            if (w_a_in == '0) begin
              w_state_nxt = S_FIRE_A;
            end else begin
              w_state_nxt = S_WAIT_A;
              w_cnt_nxt   = w_a_in - ONE;
            end
`endif
          end
        end
      end
      S_GRST: begin
`ifdef MIC4_SEQ_EXT_TRIG_EN
        // Guard is served inside WAIT_P; triggers are ignored until it expires.
        w_state_nxt = S_WAIT_P;
        w_cnt_nxt   = G_CNT - ONE;
`else
        if ((G_CNT + w_a_sh) == ONE) begin
          w_state_nxt = S_FIRE_A;
        end else begin
          w_state_nxt = S_WAIT_A;
          w_cnt_nxt   = G_CNT + w_a_sh - TWO;
        end
`endif
      end
      S_WAIT_A: begin
        if (r_cnt == '0) w_state_nxt = S_FIRE_A;
        else             w_cnt_nxt   = r_cnt - ONE;
      end
      S_FIRE_A: begin
        if (w_d_eff == ONE) begin
          w_state_nxt = S_FIRE_D;
        end else begin
          w_state_nxt = S_WAIT_D;
          w_cnt_nxt   = w_d_eff - TWO;
        end
      end
      S_WAIT_D: begin
        if (r_cnt == '0) w_state_nxt = S_FIRE_D;
        else             w_cnt_nxt   = r_cnt - ONE;
      end
      S_FIRE_D: begin
        if (w_last_shot) begin
          w_state_nxt = S_DONE;
        end else begin
`ifdef MIC4_SEQ_EXT_TRIG_EN
          w_state_nxt = S_WAIT_P;
          w_cnt_nxt   = '0;
`else
          if (w_gap == '0) begin
            w_state_nxt = S_FIRE_A;
          end else begin
            w_state_nxt = S_WAIT_P;
            w_cnt_nxt   = w_gap - ONE;
          end
`endif
        end
      end
      S_WAIT_P: begin
`ifdef MIC4_SEQ_EXT_TRIG_EN
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - ONE;
        end else if (w_trig_edge) begin
          if (w_a_sh == '0) begin
            w_state_nxt = S_FIRE_A;
          end else begin
            w_state_nxt = S_WAIT_A;
            w_cnt_nxt   = w_a_sh - ONE;
          end
        end
`else
        if (r_cnt == '0) w_state_nxt = S_FIRE_A;
        else             w_cnt_nxt   = r_cnt - ONE;
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State, wait counter and Moore outputs registered from the next state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pulse_grst <= 1'b0;
      r_pulse_a    <= 1'b0;
      r_pulse_d    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pulse_grst <= (w_state_nxt == S_GRST);
      r_pulse_a    <= (w_state_nxt == S_FIRE_A);
      r_pulse_d    <= (w_state_nxt == S_FIRE_D);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // Shadow config captured on the accepted start; shot counter cleared there and bumped with each pulse_d.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_grst_en    <= 1'b0;
      r_a_delay    <= '0;
      r_d_delay    <= '0;
      r_period     <= '0;
      r_repeat     <= '0;
      r_shot_count <= '0;
    end else if (w_start_acc) begin
      r_grst_en    <= cfg_grst_en;
      r_a_delay    <= cfg_a_delay;
      r_d_delay    <= cfg_d_delay;
      r_period     <= cfg_period;
      r_repeat     <= cfg_repeat;
      r_shot_count <= '0;
    end else if (w_state_nxt == S_FIRE_D) begin
      r_shot_count <= r_shot_count + SHOT_ONE;
    end
  end

  assign pulse_grst = r_pulse_grst;
  assign pulse_a    = r_pulse_a;
  assign pulse_d    = r_pulse_d;
  assign busy       = r_busy;
  assign done       = r_done;
  assign shot_count = r_shot_count;

endmodule

// File: tb/tb_mic4_pulse_sequencer.sv
// Bench for mic4_pulse_sequencer: expected pulse/done events are queued by the stimulus
// and checked by an independent monitor on the falling edge; status checks are directed.
`timescale 1ns/1ps
module tb_mic4_pulse_sequencer;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int GG = 8;

  localparam int K_GRST = 0;
  localparam int K_A    = 1;
  localparam int K_D    = 2;
  localparam int K_DONE = 3;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cfg_grst_en;
  logic [DW-1:0] cfg_a_delay;
  logic [DW-1:0] cfg_d_delay;
  logic [DW-1:0] cfg_period;
  logic [CW-1:0] cfg_repeat;
  logic          pulse_grst;
  logic          pulse_a;
  logic          pulse_d;
  logic          busy;
  logic          done;
  logic [CW-1:0] shot_count;

  always #5 clk_in = ~clk_in;

  mic4_pulse_sequencer #(
    .DELAY_WIDTH (DW),
    .COUNT_WIDTH (CW),
    .GRST_GUARD  (GG)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_grst_en (cfg_grst_en),
    .cfg_a_delay (cfg_a_delay),
    .cfg_d_delay (cfg_d_delay),
    .cfg_period  (cfg_period),
    .cfg_repeat  (cfg_repeat),
    .pulse_grst  (pulse_grst),
    .pulse_a     (pulse_a),
    .pulse_d     (pulse_d),
    .busy        (busy),
    .done        (done),
    .shot_count  (shot_count)
  );

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  cyc         = 0;
  int  vectors     = 0;
  int  miscompares = 0;
  logic [3:0] obs;

  // Free-running cycle stamp; read on the falling edge.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int c, input int n);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = n % (1 << CW);
    exp_q.push_back(e);
  endfunction

  // Event list of a finite run, from the timing definitions (G, A, D, P).
  function automatic void push_run(input int t0, input int g_en, input int a, input int d,
                                   input int p, input int rep);
    int g, dd, pp, ta;
    g  = g_en ? GG : 0;
    dd = (d == 0) ? 1 : d;
    pp = (p > dd) ? p : dd + 1;
    if (g_en) push(K_GRST, t0 + 1, 0);
    ta = 0;
    for (int i = 0; i < rep; i++) begin
      ta = t0 + 1 + g + a + i * pp;
      push(K_A, ta, i);
      push(K_D, ta + dd, i + 1);
    end
    push(K_DONE, ta + dd + 1, rep);
  endfunction

  task automatic compare_event(input int kind);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: unexpected kind=%0d at cycle %0d cnt=%0d", kind, cyc, shot_count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.cnt != int'(shot_count)) begin
        miscompares++;
        $display("FAIL event: got kind=%0d cyc=%0d cnt=%0d, expected kind=%0d cyc=%0d cnt=%0d",
                 kind, cyc, shot_count, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises is matched against the head of the queue.
  always @(negedge clk_in) begin
    if (!rst) begin
      obs = {done, pulse_d, pulse_a, pulse_grst};
      if (obs != 4'b0000) begin
        check("pulse_exclusive", int'($countones({pulse_d, pulse_a, pulse_grst}) <= 1), 1);
        for (int k = 0; k < 4; k++) begin
          if (obs[k]) compare_event(k);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic set_cfg(input int g, input int a, input int d, input int p, input int r);
    cfg_grst_en = (g != 0);
    cfg_a_delay = DW'(a);
    cfg_d_delay = DW'(d);
    cfg_period  = DW'(p);
    cfg_repeat  = CW'(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int t0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_in);
    check("reset_outputs", int'({busy, done, pulse_grst, pulse_a, pulse_d}), 0);
    check("reset_shot_count", int'(shot_count), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // Run 1: grst, a=10, d=20, period=50, repeat=3; restart and cfg change mid-run are ignored.
    set_cfg(1, 10, 20, 50, 3);
    t0 = cyc;
    push_run(t0, 1, 10, 20, 50, 3);
    pulse_start();
    check("run1_busy_T0p1", int'(busy), 1);
    wait_until(t0 + 50);
    pulse_start();
    wait_until(t0 + 60);
    cfg_a_delay = '0;
    wait_until(t0 + 140);
    check("run1_busy_at_done", int'(busy), 1);
    wait_until(t0 + 141);
    check("run1_busy_after", int'(busy), 0);
    check("run1_shot_count", int'(shot_count), 3);
    repeat (3) @(negedge clk_in);

    // Run 2: all-zero delays, repeat=2 (D forced to 1, P forced to 2), hand-listed.
    set_cfg(0, 0, 0, 0, 2);
    t0 = cyc;
    push(K_A,    t0 + 1, 0);
    push(K_D,    t0 + 2, 1);
    push(K_A,    t0 + 3, 1);
    push(K_D,    t0 + 4, 2);
    push(K_DONE, t0 + 5, 2);
    pulse_start();
    wait_until(t0 + 6);
    check("run2_busy_after", int'(busy), 0);
    check("run2_shot_count", int'(shot_count), 2);

    // abort together with start in IDLE: start is dropped, shot_count untouched.
    set_cfg(0, 0, 0, 0, 1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    @(negedge clk_in);
    check("abort_start_busy2", int'(busy), 0);
    check("abort_start_shot", int'(shot_count), 2);

    // Run 3: continuous mode d=1 period=2, 4-bit shot_count wraps, abort after 40 cycles.
    set_cfg(0, 0, 1, 2, 0);
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      push(K_A, t0 + 1 + 2 * i, i);
      push(K_D, t0 + 2 + 2 * i, i + 1);
    end
    pulse_start();
    wait_until(t0 + 34);
    check("run3_wrap_17th", int'(shot_count), 1);
    wait_until(t0 + 40);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    check("run3_abort_busy", int'(busy), 0);
    check("run3_abort_pulses", int'({pulse_grst, pulse_a, pulse_d, done}), 0);
    check("run3_abort_shot_hold", int'(shot_count), 4);
    repeat (3) @(negedge clk_in);
    check("run3_still_idle", int'(busy), 0);

    // Run 4: reset mid-sequence, then restart and expect run-1 timing from the new T0.
    set_cfg(1, 10, 20, 50, 3);
    t0 = cyc;
    push(K_GRST, t0 + 1, 0);
    push(K_A,    t0 + 19, 0);
    pulse_start();
    wait_until(t0 + 30);
    check("run4_busy_before_rst", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("run4_async_rst_outputs", int'({busy, done, pulse_grst, pulse_a, pulse_d}), 0);
    check("run4_async_rst_shot", int'(shot_count), 0);
    check("run4_events_seen", exp_q.size(), 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    wait_until(t0 + 100);
    t0 = cyc;
    push_run(t0, 1, 10, 20, 50, 3);
    pulse_start();
    wait_until(t0 + 141);
    check("run4_busy_after", int'(busy), 0);
    check("run4_shot_count", int'(shot_count), 3);

    repeat (5) @(negedge clk_in);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mic4_pulse_sequencer.md
Name: mic4_pulse_sequencer

Overview:
Control-clock sequencer that drives the single-cycle trigger inputs (pulse_grst, pulse_a, pulse_d) of the Mic4 control block's pulse stretchers.
- Runs a programmable test sequence: an optional global reset, then N shots. Each shot is an analog pulse followed by a digital pulse at configured delays, with shots repeating at a configured period.
- Sits between the register/command interface and the Mic4 control block, in the 100 MHz control domain.

Parameters:
- DELAY_WIDTH, 16, width of delay/period configuration fields.
- COUNT_WIDTH, 16, width of the repeat configuration and of shot_count.
- GRST_GUARD, 8, fixed cycles from the pulse_grst trigger to the start of the A-delay countdown (covers the grst stretch).

Ports:
- clk_in  input  1  control clock (100 MHz).
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sequence; sampled only in IDLE.
- abort  input  1  terminate sequence immediately.
- cfg_grst_en  input  1  issue pulse_grst before the first shot.
- cfg_a_delay  input  DELAY_WIDTH  cycles before pulse_a.
- cfg_d_delay  input  DELAY_WIDTH  cycles from pulse_a to pulse_d; 0 is treated as 1.
- cfg_period  input  DELAY_WIDTH  cycles between successive pulse_a rises.
- cfg_repeat  input  COUNT_WIDTH  shot count; 0 means continuous until abort.
- pulse_grst  output  1  one-cycle trigger to the grst stretcher.
- pulse_a  output  1  one-cycle trigger to the A stretcher.
- pulse_d  output  1  one-cycle trigger to the D stretcher.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion strobe.
- shot_count  output  COUNT_WIDTH  number of pulse_d triggers issued in the current/last run.

Behaviour:
- Reset (async): state IDLE; all outputs 0; shadow config registers cleared.
- All outputs are registered.
- Config is latched into shadow registers on the accepted start edge. Config changes while busy have no effect.
- States: IDLE, GRST, WAIT_A, FIRE_A, WAIT_D, FIRE_D, WAIT_P, DONE.
- Timing is referenced to T0, the edge at which start is sampled high in IDLE. Definitions:
  - G = GRST_GUARD if cfg_grst_en, else 0.
  - A = cfg_a_delay.
  - D = max(cfg_d_delay, 1).
  - P = max(cfg_period, D+1).
- Start handling: shot_count cleared to 0 at T0; busy = 1 from T0+1.
- pulse_grst is high for the single cycle T0+1, only if cfg_grst_en.
- First pulse_a is high for one cycle at T0+1+G+A.
- Each pulse_d is high for one cycle D cycles after its pulse_a.
- Each subsequent pulse_a rises P cycles after the previous pulse_a. GRST is never repeated between shots.
- shot_count increments in the same cycle pulse_d is high. It wraps modulo 2^COUNT_WIDTH (only reachable in continuous mode).
- Completion: after the pulse_d that makes shot_count == cfg_repeat (cfg_repeat != 0), done = 1 for the next cycle, with busy still 1. The following cycle busy = 0 and state is IDLE.
- abort in any non-IDLE state: at the next edge go to IDLE. All pulses and busy go to 0, done is not asserted, and shot_count holds its value.
- abort and start high together in IDLE: abort wins, start is ignored.
- start while busy: ignored (no restart, no queueing).
- Reset asserted mid-sequence: immediate return to reset values; no partial pulse is extended.
- At most one of pulse_grst/pulse_a/pulse_d is high in any cycle.

Optional Feature:
- Macro MIC4_SEQ_EXT_TRIG_EN.
- Defined:
  - Adds input ext_trig (1 bit, asynchronous), passed through a 2-FF synchronizer and rising-edge detected.
  - Each shot (including the first) waits in WAIT_P for a detected edge instead of counting P. pulse_a rises A+1 cycles after the edge-detect cycle; grst/G timing is unchanged and precedes the wait.
  - Edges arriving outside WAIT_P are dropped.
  - abort exits WAIT_P.
- Undefined: the ext_trig port is absent and period timing is exactly as above.

Test Plan:
- GRST_GUARD=8, grst_en=1, a=10, d=20, period=50, repeat=3, start at T0 -> pulse_grst @T0+1; pulse_a @T0+19/69/119; pulse_d @T0+39/89/139; done @T0+140; busy low @T0+141; shot_count=3.
- grst_en=0, a=0, d=0, period=0, repeat=2 -> pulse_a @T0+1, pulse_d @T0+2, pulse_a @T0+3, pulse_d @T0+4, done @T0+5.
- repeat=0, d=1, period=2, COUNT_WIDTH=4, run 40 cycles then abort -> 17th pulse_d wraps shot_count to 1; after abort, IDLE next edge, busy=0, no done.
- Run from first test; pulse start again at T0+50 and change cfg_a_delay to 0 at T0+60 -> timing identical to first test; second start ignored.
- Assert rst at T0+30 of first test -> all outputs 0 asynchronously; start at T0+100 with same config -> timing repeats relative to the new T0.
- (EXT_TRIG_EN) grst_en=0, a=5, d=3, repeat=2; ext_trig rising at cycle 20 and 60 -> pulse_a ~8 cycles after each edge (2 sync + 1 detect + A), pulse_d +3, done after the second pulse_d.
